// File: rtl/noc_pkg.sv
// Shared NoC definitions: port numbering, flit-type encoding and the position
// of the type field inside a flit.
package noc_pkg;

    localparam int NUM_PORTS = 5;
    localparam int FLIT_W    = 16;

    // Type field occupies the two MSBs of every flit
    localparam int FTYPE_MSB = 15;
    localparam int FTYPE_LSB = 14;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        EAST  = 3'd3,
        WEST  = 3'd4
    } port_e;

    typedef enum logic [1:0] {
        BODY   = 2'b00,
        HEAD   = 2'b01,
        TAIL   = 2'b10,
        SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Extract the type field of a flit
    function automatic flit_type_e get_flit_type(input logic [FLIT_W-1:0] flit);
        return flit_type_e'(flit[FTYPE_MSB:FTYPE_LSB]);
    endfunction

endpackage

// File: rtl/noc_output_arbiter_if.sv
// Output-port bundle: per-input requests/flits in, grants and the registered
// downstream write port plus credit status out.
interface noc_output_arbiter_if #(
    parameter int NUM_IN = 5,
    parameter int FLIT_W = 16
);
    logic [NUM_IN-1:0]             req_i;
    logic [NUM_IN-1:0][FLIT_W-1:0] data_i;
    logic                          credit_i;
    logic [NUM_IN-1:0]             grant_o;
    logic [FLIT_W-1:0]             data_o;
    logic                          valid_o;
    logic [2:0]                    credits_o;
    logic                          overflow_o;

    // Side that owns the input buffers and the downstream port
    modport master (
        output req_i, data_i, credit_i,
        input  grant_o, data_o, valid_o, credits_o, overflow_o
    );

    // The arbiter itself
    modport slave (
        input  req_i, data_i, credit_i,
        output grant_o, data_o, valid_o, credits_o, overflow_o
    );
endinterface

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin search: first requester at or above ptr, wrapping.
module noc_rr_arbiter #(
    parameter int NUM_IN = 5,
    parameter int IDX_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_IN-1:0] grant,
    output logic [IDX_W-1:0]  winner
);

    // Walk the ports starting at ptr and keep only the first hit
    always_comb begin
        int  idx;
        logic found;
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NUM_IN; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/noc_output_arbiter.sv
// Wormhole output arbiter: round-robin between inputs, holds the output for a
// whole packet once a HEAD wins, and gates sends on downstream credits.
module noc_output_arbiter
    import noc_pkg::*;
#(
    parameter int NUM_IN = 5,
    parameter int FLIT_W = 16,
    parameter int DEPTH  = 5
) (
    input logic                clk,
    input logic                rst,
    noc_output_arbiter_if.slave bus
);

    localparam int                IDX_W    = $clog2(NUM_IN);
    localparam int                CNT_W    = 3;
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_IN - 1);

    arb_state_e        state_reg;
    logic [IDX_W-1:0]  owner_reg;
    logic [IDX_W-1:0]  rr_ptr_reg;
    logic [CNT_W-1:0]  credits_reg;
    logic [FLIT_W-1:0] data_o_reg;
    logic              valid_reg;
    logic              overflow_reg;

    logic [NUM_IN-1:0] rr_grant;
    logic [IDX_W-1:0]  rr_winner;
    logic [NUM_IN-1:0] grant;
    logic [IDX_W-1:0]  winner;
    logic              send;
    logic [FLIT_W-1:0] win_flit;
    flit_type_e        win_type;
    logic              pkt_done;
    logic [IDX_W-1:0]  rr_ptr_next;

    noc_rr_arbiter #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_rr (
        .req    (bus.req_i),
        .ptr    (rr_ptr_reg),
        .grant  (rr_grant),
        .winner (rr_winner)
    );

    // Grant selection: round-robin when idle, owner only when locked
    always_comb begin
        grant  = '0;
        winner = rr_winner;
        if (!rst && credits_reg != '0) begin
            if (state_reg == ST_IDLE) begin
                grant = rr_grant;
            end else begin
                winner           = owner_reg;
                grant[owner_reg] = bus.req_i[owner_reg];
            end
        end
    end

    assign send        = |grant;
    assign win_flit    = bus.data_i[winner];
    assign win_type    = flit_type_e'(win_flit[FTYPE_MSB:FTYPE_LSB]);
    // A packet ends on TAIL/SINGLE, or on a stray BODY that won while idle
    assign pkt_done    = (win_type == TAIL) || (win_type == SINGLE) ||
                         ((state_reg == ST_IDLE) && (win_type == BODY));
    assign rr_ptr_next = (winner == LAST_IDX) ? '0 : winner + 1'b1;

    // Lock FSM, round-robin pointer, credit counter and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            owner_reg    <= '0;
            rr_ptr_reg   <= '0;
            credits_reg  <= DEPTH_C;
            data_o_reg   <= '0;
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            valid_reg <= send;
            if (send) begin
                data_o_reg <= win_flit;
                if (pkt_done) begin
                    rr_ptr_reg <= rr_ptr_next;
                end
                case (state_reg)
                    ST_IDLE: begin
                        if (win_type == HEAD) begin
                            state_reg <= ST_LOCKED;
                            owner_reg <= winner;
                        end
                    end
                    default: begin
                        if (win_type == TAIL || win_type == SINGLE) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                endcase
            end
            case ({send, bus.credit_i})
                2'b10: credits_reg <= credits_reg - 1'b1;
                2'b01: begin
                    if (credits_reg == DEPTH_C) begin
                        overflow_reg <= 1'b1;
                    end else begin
                        credits_reg <= credits_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.grant_o    = grant;
    assign bus.data_o     = data_o_reg;
    assign bus.valid_o    = valid_reg;
    assign bus.credits_o  = credits_reg;
    assign bus.overflow_o = overflow_reg;

endmodule

// File: doc/noc_output_arbiter.md
NOC_OUTPUT_ARBITER -- requirements
Module: noc_output_arbiter

Interface
REQ-001 Parameter NUM_IN, default 5, is the number of competing input ports (LOCAL, NORTH, SOUTH, EAST, WEST).
REQ-002 Parameter FLIT_W, default 16, is the flit width in bits.
REQ-003 Parameter DEPTH, default 5, is the downstream buffer depth and the initial credit count.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_i  input  NUM_IN  per-port request: the port's buffer is non-empty and its head flit is routed to this output.
REQ-007 data_i  input  NUM_IN x FLIT_W  per-port head flit.
REQ-008 credit_i  input  1  one-cycle pulse: downstream popped one entry.
REQ-009 grant_o  output  NUM_IN  one-hot pop pulse to the winning input port, same cycle.
REQ-010 data_o  output  FLIT_W  registered flit to the downstream port.
REQ-011 valid_o  output  1  registered write enable to the downstream port.
REQ-012 credits_o  output  3  current credit count, range 0..DEPTH.
REQ-013 overflow_o  output  1  sticky error flag: a credit was returned while the count was already at DEPTH.

Function
REQ-014 Flit type is data[15:14]: 01 = HEAD, 00 = BODY, 10 = TAIL, 11 = SINGLE (head and tail in one flit).
REQ-015 The FSM has two states, IDLE and LOCKED, plus a lock register holding the owner port index.
REQ-016 IDLE: when credits > 0 and any req_i is set, grant the first requester found from rr_ptr upward, modulo NUM_IN.
REQ-017 IDLE transitions: a granted HEAD moves to LOCKED with owner = winner; a granted SINGLE, TAIL or BODY stays in IDLE.
REQ-018 LOCKED: grant only the owner, and only when req_i[owner] = 1 and credits > 0; all other requests are ignored.
REQ-019 LOCKED transitions: a granted TAIL or SINGLE returns to IDLE; otherwise the state stays LOCKED.
REQ-020 rr_ptr updates to (winner + 1) mod NUM_IN only when a packet completes, i.e. on a SINGLE/TAIL grant, or on a BODY grant in IDLE.
REQ-021 grant_o is combinational and at most one-hot, and is all-zero when credits = 0, when no request is eligible, or when rst = 1.
REQ-022 Latency: one cycle. A grant in cycle N gives valid_o = 1 and data_o = data_i[winner] in cycle N+1.
REQ-023 With no grant, valid_o = 0 and data_o holds its last value.
REQ-024 Credit update: next = credits - send + credit_i.
REQ-025 Simultaneous send and credit leaves the count unchanged, including at 0 and at DEPTH.
REQ-026 credit_i with credits = DEPTH and no send: the count saturates at DEPTH and overflow_o is set until reset.
REQ-027 credits = 0: no grant is issued, and a credit_i in that cycle makes a grant possible the following cycle.
REQ-028 A grant is never issued to a port with req_i = 0.

Reset
REQ-029 rst = 1 for one or more cycles sets: state IDLE, rr_ptr 0, lock owner 0, credits DEPTH, valid_o 0, data_o 0, overflow_o 0.
REQ-030 rst mid-packet abandons the lock; the first cycle after reset arbitrates from IDLE with rr_ptr 0.
REQ-031 credit_i and req_i are ignored while rst = 1.

Structure
REQ-032 The shared package noc_pkg holds: NUM_PORTS = 5, FLIT_W = 16, port enum {LOCAL, NORTH, SOUTH, EAST, WEST}, flit-type enum {BODY, HEAD, TAIL, SINGLE}, and the flit-type field position.
REQ-033 Sub-module noc_rr_arbiter: a combinational priority search from rr_ptr, outputting one-hot grant and winner index.
REQ-034 The FSM, credit counter and output register live in noc_output_arbiter.

Verification
REQ-035 After reset, req_i = 5'b00110 with SINGLE flits held for 4 cycles -> grants 00010, 00100, 00010, 00100; valid_o high from cycle 2.
REQ-036 Port 0 sends HEAD, BODY, TAIL while req_i = 5'b00011 throughout -> 3 grants to port 0 in 3 cycles, then port 1 is granted.
REQ-037 5 SINGLE grants with no credit_i -> credits_o = 0, grant_o = 0 while requests persist; one credit_i pulse -> exactly one grant the next cycle.
REQ-038 Credits = 0, credit_i and a request in the same cycle -> no grant that cycle, grant in the next cycle, credits_o returns to 0.
REQ-039 credit_i pulse at credits = 5 -> credits_o stays 5 and overflow_o = 1 until rst.
REQ-040 rst asserted while LOCKED on port 3 with req_i = 5'b01001 -> after reset, port 0 is granted first.
